// File: rtl/apb_master_bridge_if.sv
// Bundle of the core request/response channels and the APB4 master port.
// "master" is the bridge's view; "slave" is the environment's view (core + APB slave).
interface apb_master_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB = DATA_WIDTH / 8;

    // Core request channel
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_write;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [STRB-1:0]       req_wstrb;
    logic [2:0]            req_prot;

    // Core response channel
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    // APB4 master port
    logic [ADDR_WIDTH-1:0] apb_paddr;
    logic [2:0]            apb_pprot;
    logic                  apb_psel;
    logic                  apb_penable;
    logic                  apb_pwrite;
    logic [DATA_WIDTH-1:0] apb_pwdata;
    logic [STRB-1:0]       apb_pstrb;
    logic [DATA_WIDTH-1:0] apb_prdata;
    logic                  apb_pready;
    logic                  apb_pslverr;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata, req_wstrb, req_prot,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output apb_paddr, apb_pprot, apb_psel, apb_penable, apb_pwrite, apb_pwdata, apb_pstrb,
        input  apb_prdata, apb_pready, apb_pslverr
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata, req_wstrb, req_prot,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  apb_paddr, apb_pprot, apb_psel, apb_penable, apb_pwrite, apb_pwdata, apb_pstrb,
        output apb_prdata, apb_pready, apb_pslverr
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Valid/ready load-store request to APB4 master bridge.
// One outstanding transfer, registered APB outputs, per-transfer ACCESS timeout.
module apb_master_bridge #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input logic                clk,
    input logic                rst,
    apb_master_bridge_if.master bus
);
    localparam int unsigned STRB  = DATA_WIDTH / 8;
    localparam int unsigned CNT_W = 16;

    // Clears the sub-word byte offset so paddr is always bus-word aligned.
    localparam logic [ADDR_WIDTH-1:0] AddrMask = ~ADDR_WIDTH'(STRB - 1);
    // Count value at which the last permitted ACCESS cycle expires.
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [2:0]            pprot_q, pprot_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [STRB-1:0]       pstrb_q, pstrb_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    // State and datapath registers; reset clears every registered output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            paddr_q  <= '0;
            pprot_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            paddr_q  <= paddr_d;
            pprot_q  <= pprot_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            pstrb_q  <= pstrb_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic: accept, one SETUP cycle, ACCESS until pready or timeout, hold response.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        paddr_d  = paddr_q;
        pprot_d  = pprot_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            StIdle: begin
                if (bus.req_valid && ready_q) begin
                    paddr_d  = bus.req_addr & AddrMask;
                    pprot_d  = bus.req_prot;
                    pwrite_d = bus.req_write;
                    // Reads drive no data and no strobes onto the bus.
                    pwdata_d = bus.req_write ? bus.req_wdata : '0;
                    pstrb_d  = bus.req_write ? bus.req_wstrb : '0;
                    cnt_d    = '0;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                state_d = StAccess;
            end
            StAccess: begin
                if (bus.apb_pready) begin
                    // Read data is returned only for successful reads.
                    rdata_d = (pwrite_q || bus.apb_pslverr) ? '0 : bus.apb_prdata;
                    err_d   = bus.apb_pslverr;
                    state_d = StResp;
                end else if (TimeoutEn && (cnt_q == TimeoutLast)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else if (TimeoutEn) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Registered so req_ready stays low while reset is asserted.
        ready_d = (state_d == StIdle);
    end

    // Outputs decoded from the state register or driven straight from captured registers.
    assign bus.req_ready   = ready_q;
    assign bus.rsp_valid   = (state_q == StResp);
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_err     = err_q;
    assign bus.apb_psel    = (state_q == StSetup) || (state_q == StAccess);
    assign bus.apb_penable = (state_q == StAccess);
    assign bus.apb_paddr   = paddr_q;
    assign bus.apb_pprot   = pprot_q;
    assign bus.apb_pwrite  = pwrite_q;
    assign bus.apb_pwdata  = pwdata_q;
    assign bus.apb_pstrb   = pstrb_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: a response scoreboard plus
// cycle-by-cycle checks of the APB phases. Inputs are driven and outputs
// sampled on the falling clock edge.
module tb_apb_master_bridge;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;
    localparam int          BOUND = 40;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master_bridge #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"}, bus.req_ready, 0);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
        check({tag, "_rsp_err"}, bus.rsp_err, 0);
        check({tag, "_psel"}, bus.apb_psel, 0);
        check({tag, "_penable"}, bus.apb_penable, 0);
        check({tag, "_paddr"}, bus.apb_paddr, 0);
        check({tag, "_pprot"}, bus.apb_pprot, 0);
        check({tag, "_pwrite"}, bus.apb_pwrite, 0);
        check({tag, "_pwdata"}, bus.apb_pwdata, 0);
        check({tag, "_pstrb"}, bus.apb_pstrb, 0);
    endtask

    // Present a request, wait for acceptance, then play the APB slave.
    // waits < 0 means pready never rises. Returns at the first RESP sample.
    task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [2:0] prot, input int waits,
                         input logic slverr, input logic [31:0] prdata, input bit imm);
        int          n;
        int          acc;
        rsp_t        e;
        logic [31:0] ea;
        logic [31:0] ewd;
        logic [3:0]  est;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_write = wr;
        bus.req_wdata = wdata;
        bus.req_wstrb = wstrb;
        bus.req_prot  = prot;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check("accept_bound", (n < BOUND), 1);
        if (imm) check("accept_immediate", n, 0);
        e.err   = slverr || (waits < 0);
        e.rdata = (wr || e.err) ? 32'h0 : prdata;
        sb.push_back(e);
        ea  = addr & 32'hFFFF_FFFC;
        ewd = wr ? wdata : 32'h0;
        est = wr ? wstrb : 4'h0;

        @(negedge clk);
        bus.req_valid = 1'b0;
        check("setup_psel", bus.apb_psel, 1);
        check("setup_penable", bus.apb_penable, 0);
        check("setup_req_ready", bus.req_ready, 0);
        check("setup_paddr", bus.apb_paddr, ea);
        check("setup_pwrite", bus.apb_pwrite, wr);
        check("setup_pwdata", bus.apb_pwdata, ewd);
        check("setup_pstrb", bus.apb_pstrb, est);
        check("setup_pprot", bus.apb_pprot, prot);

        acc = 0;
        while (acc < BOUND) begin
            @(negedge clk);
            if (!(bus.apb_psel && bus.apb_penable)) break;
            check("acc_paddr", bus.apb_paddr, ea);
            check("acc_pwrite", bus.apb_pwrite, wr);
            check("acc_pwdata", bus.apb_pwdata, ewd);
            check("acc_pstrb", bus.apb_pstrb, est);
            check("acc_pprot", bus.apb_pprot, prot);
            check("acc_rsp_valid", bus.rsp_valid, 0);
            bus.apb_pready = (waits >= 0) && (acc == waits);
            // Garbage on prdata/pslverr while not ready must be ignored.
            bus.apb_prdata  = bus.apb_pready ? prdata : 32'hDEAD_BEEF;
            bus.apb_pslverr = bus.apb_pready ? slverr : 1'b1;
            acc++;
        end
        bus.apb_pready  = 1'b0;
        bus.apb_pslverr = 1'b0;
        bus.apb_prdata  = 32'h0;
        check("access_cycles", acc, (waits >= 0) ? waits + 1 : TO);
        check("resp_valid", bus.rsp_valid, 1);
        check("resp_psel", bus.apb_psel, 0);
        check("resp_penable", bus.apb_penable, 0);
        check("resp_req_ready", bus.req_ready, 0);
    endtask

    // Hold off rsp_ready for 'stall' cycles, then consume and score the response.
    task automatic collect(input int stall);
        rsp_t        e;
        logic [31:0] r0;
        logic        e0;
        r0 = bus.rsp_rdata;
        e0 = bus.rsp_err;
        for (int i = 0; i < stall; i++) begin
            bus.rsp_ready = 1'b0;
            @(negedge clk);
            check("bp_rsp_valid", bus.rsp_valid, 1);
            check("bp_rsp_rdata", bus.rsp_rdata, r0);
            check("bp_rsp_err", bus.rsp_err, e0);
            check("bp_req_ready", bus.req_ready, 0);
        end
        check("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("rsp_valid_at_pop", bus.rsp_valid, 1);
            check("rsp_rdata", bus.rsp_rdata, e.rdata);
            check("rsp_err", bus.rsp_err, e.err);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("post_rsp_valid", bus.rsp_valid, 0);
        check("post_req_ready", bus.req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic        wr;
        int          w;
        logic [31:0] a;
        bus.req_valid   = 1'b0;
        bus.req_addr    = '0;
        bus.req_write   = 1'b0;
        bus.req_wdata   = '0;
        bus.req_wstrb   = '0;
        bus.req_prot    = '0;
        bus.rsp_ready   = 1'b0;
        bus.apb_prdata  = '0;
        bus.apb_pready  = 1'b0;
        bus.apb_pslverr = 1'b0;

        #2 rst = 1'b1;
        #1 check_zero("reset");
        repeat (2) @(negedge clk);
        check_zero("reset_held");
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait read
        issue(32'h1000_0004, 1'b0, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'hCAFE_F00D, 1'b0);
        collect(0);

        // Write with 3 wait states
        issue(32'h2000_0008, 1'b1, 32'h1234_5678, 4'h3, 3'b010, 3, 1'b0, 32'h0, 1'b0);
        collect(0);

        // Slave error on an unaligned read
        issue(32'h0000_0013, 1'b0, 32'h0, 4'hF, 3'b001, 0, 1'b1, 32'h0, 1'b0);
        collect(0);

        // Timeout, then a normal read
        issue(32'h4000_0000, 1'b0, 32'h0, 4'h0, 3'b000, -1, 1'b0, 32'h0, 1'b0);
        collect(0);
        issue(32'h4000_0010, 1'b0, 32'h0, 4'h0, 3'b000, 1, 1'b0, 32'h0000_55AA, 1'b0);
        collect(0);

        // Response backpressure with the next request already waiting
        issue(32'h5000_0000, 1'b1, 32'hA5A5_5A5A, 4'hF, 3'b000, 0, 1'b0, 32'h0, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h5000_0004;
        bus.req_write = 1'b0;
        bus.req_prot  = 3'b100;
        collect(5);
        issue(32'h5000_0004, 1'b0, 32'h0, 4'h0, 3'b100, 0, 1'b0, 32'h7777_0001, 1'b1);
        collect(0);

        // Reset asserted during ACCESS abandons the transfer
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h3000_0000;
        bus.req_write = 1'b0;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("rst_pre_penable", bus.apb_penable, 1);
        rst = 1'b1;
        #1 check_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_after_rsp_valid", bus.rsp_valid, 0);
            check("rst_after_psel", bus.apb_psel, 0);
        end
        check("rst_sb_empty", sb.size(), 0);
        issue(32'h6000_000C, 1'b0, 32'h0, 4'h0, 3'b101, 2, 1'b0, 32'h0BAD_C0DE, 1'b0);
        collect(0);

        // Mixed traffic
        for (int k = 0; k < 6; k++) begin
            wr = 1'(k % 2);
            w  = int'($urandom_range(0, 3));
            a  = $urandom;
            issue(a, wr, $urandom, 4'($urandom), 3'($urandom), w, 1'b0, $urandom, 1'b0);
            collect(int'($urandom_range(0, 2)));
        end

        check("sb_empty_end", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
